// File: rtl/struct_test_pkg.sv
// -----------------------------------------------------------------------------
// struct_test_pkg
// Shared definitions for the event statistics controller:
//   NCHAN, PEAK_W, TS_W  - channel count, sample width, timestamp width
//   event_stat_struct    - completed record: per-channel peaks + start timestamp
//   state_t              - controller FSM states (IDLE, COLLECT, EMIT)
//   peak_max()           - unsigned full-width maximum used by the peak hold
// -----------------------------------------------------------------------------
package struct_test_pkg;

   localparam int NCHAN  = 4;
   localparam int PEAK_W = 16;
   localparam int TS_W   = 32;

   typedef struct packed {
      logic [NCHAN-1:0][PEAK_W-1:0] peak;
      logic [TS_W-1:0]              timestamp;
   } event_stat_struct;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   // Unsigned compare at full width, so a peak can only grow and never wraps.
   function automatic logic [PEAK_W-1:0] peak_max(input logic [PEAK_W-1:0] cur,
                                                  input logic [PEAK_W-1:0] smp);
      return (smp > cur) ? smp : cur;
   endfunction

endpackage

// File: rtl/event_stat_peak.sv
// -----------------------------------------------------------------------------
// event_stat_peak
// One channel of max-hold tracking.
// Ports:
//   clk, resetn  - clock, asynchronous active-low reset
//   clear        - zero the held peak (start of a new window); wins over valid
//   valid        - fold sample into the held peak this cycle
//   sample       - unsigned channel sample
//   peak         - held maximum since the last clear
// -----------------------------------------------------------------------------
module event_stat_peak
   import struct_test_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              clear,
   input  logic              valid,
   input  logic [PEAK_W-1:0] sample,
   output logic [PEAK_W-1:0] peak
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         peak <= '0;
      end else if (clear) begin
         peak <= '0;
      end else if (valid) begin
         peak <= peak_max(peak, sample);
      end
   end

endmodule

// File: rtl/event_stat_ctrl.sv
// -----------------------------------------------------------------------------
// event_stat_ctrl
// Collects per-channel peak values over a window of WINDOW_LEN accepted
// samples following a trigger, then presents one record with a
// valid/ready handshake.
// Parameter:
//   WINDOW_LEN   - accepted samples per window (1..65535)
// Ports:
//   clk          - clock, rising edge
//   resetn       - asynchronous active-low reset
//   trig         - event start pulse (ignored while a window is in flight)
//   samp_valid   - sample qualifier
//   samp         - NCHAN packed unsigned samples, channel i at [i*PEAK_W +: PEAK_W]
//   stat_ready   - downstream accept
//   stat         - completed record (peaks + timestamp of the trig cycle)
//   stat_valid   - record valid, only in EMIT
//   busy         - high in COLLECT or EMIT
//   drop_count   - (only with EVENT_STAT_DROP_CNT_EN) saturating count of
//                  ignored trigs
// Build option: define EVENT_STAT_DROP_CNT_EN to add the drop_count output.
// -----------------------------------------------------------------------------
module event_stat_ctrl
   import struct_test_pkg::*;
#(
   parameter int unsigned WINDOW_LEN = 16
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    trig,
   input  logic                    samp_valid,
   input  logic [NCHAN*PEAK_W-1:0] samp,
   input  logic                    stat_ready,
   output event_stat_struct        stat,
   output logic                    stat_valid,
   output logic                    busy
`ifdef EVENT_STAT_DROP_CNT_EN
   ,
   output logic [15:0]             drop_count
`endif
);

   localparam logic [15:0] CNT_LAST = 16'(WINDOW_LEN - 1);

   state_t                       state;
   logic [TS_W-1:0]              ts_cnt;
   logic [TS_W-1:0]              ts_lat;
   logic [15:0]                  samp_cnt;
   logic [NCHAN-1:0][PEAK_W-1:0] peak_w;
   logic                         hs;
   logic                         clr;
   logic                         acc;

   assign hs  = (state == EMIT) && stat_valid && stat_ready;
   // A new window opens from IDLE, or back-to-back on the handshake cycle.
   assign clr = trig && ((state == IDLE) || hs);
   // The trig cycle itself is never in COLLECT, so its sample is skipped.
   assign acc = (state == COLLECT) && samp_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ts_cnt <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         stat_valid <= 1'b0;
         busy       <= 1'b0;
         samp_cnt   <= '0;
         ts_lat     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trig) begin
                  state    <= COLLECT;
                  busy     <= 1'b1;
                  samp_cnt <= '0;
                  ts_lat   <= ts_cnt;
               end
            end
            COLLECT: begin
               if (samp_valid) begin
                  samp_cnt <= samp_cnt + 16'd1;
                  if (samp_cnt == CNT_LAST) begin
                     state      <= EMIT;
                     stat_valid <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (stat_ready) begin
                  stat_valid <= 1'b0;
                  if (trig) begin
                     state    <= COLLECT;
                     samp_cnt <= '0;
                     ts_lat   <= ts_cnt;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               stat_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NCHAN; i++) begin : g_peak
      event_stat_peak u_peak (
         .clk    (clk),
         .resetn (resetn),
         .clear  (clr),
         .valid  (acc),
         .sample (samp[i*PEAK_W +: PEAK_W]),
         .peak   (peak_w[i])
      );
   end

   assign stat.peak      = peak_w;
   assign stat.timestamp = ts_lat;

`ifdef EVENT_STAT_DROP_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic drop;
   assign drop = trig && ((state == COLLECT) || ((state == EMIT) && !hs));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_count <= '0;
      end else if (drop) begin
         drop_count <= sat_inc(drop_count);
      end
   end
`endif

endmodule

// File: tb/tb_event_stat_ctrl.sv
`timescale 1ns/1ps
module tb_event_stat_ctrl;
   import struct_test_pkg::*;

   localparam int WL = 4;

   logic                    clk        = 1'b0;
   logic                    resetn     = 1'b0;
   logic                    trig       = 1'b0;
   logic                    samp_valid = 1'b0;
   logic                    stat_ready = 1'b0;
   logic [NCHAN*PEAK_W-1:0] samp       = '0;
   event_stat_struct        stat;
   logic                    stat_valid;
   logic                    busy;
`ifdef EVENT_STAT_DROP_CNT_EN
   logic [15:0]             drop_count;
   int                      exp_drop = 0;
`endif

   typedef struct {
      event_stat_struct rec;
      bit               ts_small;
   } exp_t;

   exp_t             exp_q[$];
   int               n_chk  = 0;
   int               n_fail = 0;
   logic [TS_W-1:0]  tb_cyc;
   logic [PEAK_W-1:0] mpeak [NCHAN];
   logic [TS_W-1:0]  m_ts;
   event_stat_struct last_rec;

   event_stat_ctrl #(.WINDOW_LEN(WL)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .trig       (trig),
      .samp_valid (samp_valid),
      .samp       (samp),
      .stat_ready (stat_ready),
      .stat       (stat),
      .stat_valid (stat_valid),
      .busy       (busy)
`ifdef EVENT_STAT_DROP_CNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference cycle count: equals the DUT timestamp counter in the current cycle.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) tb_cyc <= '0;
      else         tb_cyc <= tb_cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pk(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic [15:0] d);
      return {d, c, b, a};
   endfunction

   // Compare any record handed over on the coming edge, then advance one cycle.
   task automatic tick();
      exp_t e;
      if (stat_valid === 1'b1 && stat_ready === 1'b1) begin
         chk("sb_record_expected", (exp_q.size() != 0), 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int c = 0; c < NCHAN; c++)
               chk($sformatf("rec_peak%0d", c), stat.peak[c], e.rec.peak[c]);
            if (e.ts_small) chk("rec_ts_after_wrap_small", (stat.timestamp < 64), 1'b1);
            else            chk("rec_ts", stat.timestamp, e.rec.timestamp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Drive trig for the coming edge; the sample on this cycle must be ignored.
   task automatic start();
      trig       = 1'b1;
      samp_valid = 1'b1;
      samp       = '1;
      m_ts       = tb_cyc;
      for (int c = 0; c < NCHAN; c++) mpeak[c] = '0;
   endtask

   task automatic sample(input logic [63:0] v, input int gap, input bit last, input bit ts_small);
      exp_t e;
      chk("busy_collect", busy, 1'b1);
      samp_valid = 1'b1;
      samp       = v;
      for (int c = 0; c < NCHAN; c++)
         if (v[c*16 +: 16] > mpeak[c]) mpeak[c] = v[c*16 +: 16];
      if (last) begin
         e.rec.timestamp = m_ts;
         for (int c = 0; c < NCHAN; c++) e.rec.peak[c] = mpeak[c];
         e.ts_small = ts_small;
         last_rec   = e.rec;
         exp_q.push_back(e);
      end
      tick();
      samp_valid = 1'b0;
      samp       = '1;
      for (int g = 0; g < gap; g++) begin
         chk("no_early_valid", stat_valid, 1'b0);
         tick();
      end
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_stat_valid", stat_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_stat", stat, '0);
      resetn = 1'b1;

      // Basic window, trig at counter 10, ready already high
      stat_ready = 1'b1;
      repeat (20) if (tb_cyc != 10) tick();
      start();
      tick();
      trig = 1'b0;
      chk("busy_after_trig", busy, 1'b1);
      sample(pk(3, 1, 100, 8000), 0, 0, 0);
      sample(pk(9, 2, 50, 0), 0, 0, 0);
      sample(pk(2, 3, 200, 0), 0, 0, 0);
      chk("valid_before_last", stat_valid, 1'b0);
      sample(pk(7, 4, 0, 1), 0, 1, 0);
      chk("valid_after_last", stat_valid, 1'b1);
      chk("basic_peak0", stat.peak[0], 16'd9);
      chk("basic_ts", stat.timestamp, 32'd10);
      tick();
      chk("valid_after_hs", stat_valid, 1'b0);
      chk("busy_after_hs", busy, 1'b0);

      // Backpressure: 5 stalled cycles, a trig in EMIT is dropped
      stat_ready = 1'b0;
      tick();
      start();
      tick();
      trig = 1'b0;
      sample(pk(10, 20, 30, 40), 0, 0, 0);
      sample(pk(11, 5, 31, 1), 0, 0, 0);
      sample(pk(1, 21, 2, 39), 0, 0, 0);
      sample(pk(0, 0, 0, 41), 0, 1, 0);
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", stat_valid, 1'b1);
         chk("stall_stat", stat, last_rec);
         chk("stall_busy", busy, 1'b1);
         trig = (k == 2);
`ifdef EVENT_STAT_DROP_CNT_EN
         if (k == 2) exp_drop++;
`endif
         tick();
      end
      trig       = 1'b0;
      stat_ready = 1'b1;
      tick();
      chk("stall_valid_after_hs", stat_valid, 1'b0);
      chk("stall_busy_after_hs", busy, 1'b0);
      tick();
      chk("single_hs_valid", stat_valid, 1'b0);
      chk("single_hs_busy", busy, 1'b0);

      // Trig dropped in COLLECT, then trig coincident with handshake
      stat_ready = 1'b0;
      start();
      tick();
      trig = 1'b0;
      sample(pk(1, 1, 1, 1), 0, 0, 0);
      trig = 1'b1;
`ifdef EVENT_STAT_DROP_CNT_EN
      exp_drop++;
`endif
      sample(pk(2, 2, 2, 2), 0, 0, 0);
      trig = 1'b0;
      sample(pk(3, 3, 3, 3), 0, 0, 0);
      sample(pk(0, 4, 0, 0), 0, 1, 0);
      chk("drop_window_valid", stat_valid, 1'b1);
      stat_ready = 1'b1;
      start();
      tick();
      trig       = 1'b0;
      stat_ready = 1'b0;
      chk("hs_trig_busy", busy, 1'b1);
      chk("hs_trig_valid", stat_valid, 1'b0);
      // Gapped valid, full-scale and zero samples
      sample(pk(16'hFFFF, 7, 0, 100), 2, 0, 0);
      sample(pk(0, 3, 0, 99), 2, 0, 0);
      sample(pk(16'hFFFF, 1, 0, 5), 2, 0, 0);
      sample(pk(0, 0, 0, 0), 0, 1, 0);
      chk("gap_valid", stat_valid, 1'b1);
      chk("gap_peak0_full_scale", stat.peak[0], 16'hFFFF);
      stat_ready = 1'b1;
      tick();
      chk("gap_valid_after_hs", stat_valid, 1'b0);
      chk("gap_busy_after_hs", busy, 1'b0);
`ifdef EVENT_STAT_DROP_CNT_EN
      chk("drop_count", drop_count, exp_drop);
`endif

      // Reset in the middle of a window
      start();
      tick();
      trig = 1'b0;
      sample(pk(50, 50, 50, 50), 0, 0, 0);
      sample(pk(60, 60, 60, 60), 0, 0, 0);
      resetn = 1'b0;
      #1;
      chk("midrst_valid", stat_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_stat", stat, '0);
`ifdef EVENT_STAT_DROP_CNT_EN
      exp_drop = 0;
      chk("midrst_drop_count", drop_count, exp_drop);
`endif
      tick();
      tick();
      chk("midrst_valid_held", stat_valid, 1'b0);
      resetn = 1'b1;
      start();
      tick();
      trig = 1'b0;
      sample(pk(5, 6, 7, 8), 0, 0, 0);
      sample(pk(1, 9, 2, 3), 0, 0, 0);
      sample(pk(4, 4, 4, 4), 0, 0, 0);
      sample(pk(0, 0, 9, 0), 0, 1, 0);
      chk("fresh_ts_first_edge", stat.timestamp, 32'd0);
      tick();
      chk("fresh_busy_after_hs", busy, 1'b0);

      // Trig with the counter at all-ones, then a trig after wrap
      tick();
      force dut.ts_cnt = 32'hFFFF_FFFF;
      start();
      m_ts = 32'hFFFF_FFFF;
      tick();
      release dut.ts_cnt;
      trig = 1'b0;
      sample(pk(12, 0, 0, 0), 0, 0, 0);
      sample(pk(13, 0, 0, 0), 0, 0, 0);
      sample(pk(14, 0, 0, 0), 0, 0, 0);
      sample(pk(1, 2, 3, 4), 0, 1, 0);
      chk("wrap_ts_all_ones", stat.timestamp, 32'hFFFF_FFFF);
      tick();
      start();
      tick();
      trig = 1'b0;
      sample(pk(1, 1, 1, 1), 0, 0, 0);
      sample(pk(2, 2, 2, 2), 0, 0, 0);
      sample(pk(3, 3, 3, 3), 0, 0, 0);
      sample(pk(4, 4, 4, 4), 0, 1, 1);
      chk("after_wrap_valid", stat_valid, 1'b1);
      tick();
      chk("after_wrap_busy", busy, 1'b0);

      chk("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
